// File: rtl/ahb_master_burst_req.sv
// AHB burst master request sequencer: IDLE -> REQ (arbitration) -> BURST beats.
// Optional grant-wait timeout enabled by defining REQ_TIMEOUT_EN.
package AHB_package;
    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;
endpackage

// state | meaning
// S_IDLE  | ready for a command, bus released
// S_REQ   | command latched, requesting the bus, waiting for hgrant
// S_BURST | driving beats; a beat is accepted in each hgrant cycle
module ahb_master_burst_req
    import AHB_package::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  hburst_type        cmd_burst,
    input  logic              cmd_write,
    output logic              hreq,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output hburst_type        hburst,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic              beat_done,
    output logic              burst_done,
    output logic              req_timeout
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_BURST = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    hburst_type        burst_q, burst_d;
    logic              write_q, write_d;
    logic [3:0]        beat_q, beat_d;

    logic [3:0]        beat_limit;
    logic              is_wrap;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic              timeout_hit;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[1:0];

    always_comb begin
        beat_limit = 4'd0;
        case (burst_q)
            WRAP4,  INCR4:  beat_limit = 4'd3;
            WRAP8,  INCR8:  beat_limit = 4'd7;
            WRAP16, INCR16: beat_limit = 4'd15;
            default:        beat_limit = 4'd0;
        endcase
    end

    assign is_wrap = (burst_q == WRAP4) || (burst_q == WRAP8) || (burst_q == WRAP16);

    // Wrap boundary mask is 4*(limit+1)-1, i.e. {limit, 2'b11}.
    assign wrap_mask = {{(ADDR_W-6){1'b0}}, beat_limit, 2'b11};
    assign addr_inc  = addr_q + ADDR_W'(4);
    assign addr_next = is_wrap ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;

`ifdef REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Down-counter reloaded while idle; terminal count zero marks the last REQ cycle.
    always_comb begin
        wait_d = wait_q;
        if (state_q == S_IDLE) begin
            wait_d = WAIT_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == S_REQ) && !hgrant && (wait_q != '0)) begin
            wait_d = wait_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_q <= WAIT_W'(TIMEOUT_CYCLES - 1);
        end else begin
            wait_q <= wait_d;
        end
    end

    assign timeout_hit = (wait_q == '0);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            burst_q <= SINGLE;
            write_q <= 1'b0;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            write_q <= write_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        write_d     = write_q;
        beat_d      = beat_q;
        cmd_ready   = 1'b0;
        hreq        = 1'b0;
        htrans      = HT_IDLE;
        beat_done   = 1'b0;
        burst_done  = 1'b0;
        req_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    burst_d = cmd_burst;
                    write_d = cmd_write;
                    beat_d  = 4'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                hreq = 1'b1;
                if (hgrant) begin
                    state_d = S_BURST;
                end else if (timeout_hit) begin
                    req_timeout = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_BURST: begin
                hreq   = 1'b1;
                htrans = (beat_q == 4'd0) ? HT_NONSEQ : HT_SEQ;
                if (hgrant) begin
                    beat_done = 1'b1;
                    beat_d    = beat_q + 4'd1;
                    addr_d    = addr_next;
                    if (beat_q == beat_limit) begin
                        burst_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign haddr  = addr_q;
    assign hburst = burst_q;
    assign hwrite = write_q;
    assign hsize  = 3'b010;

endmodule

// File: tb/tb_ahb_master_burst_req.sv
// Directed bench for ahb_master_burst_req; timeout checks follow REQ_TIMEOUT_EN.
module tb_ahb_master_burst_req;
    import AHB_package::*;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;

    logic              hclk;
    logic              hreset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    hburst_type        cmd_burst;
    logic              cmd_write;
    logic              hreq;
    logic              hgrant;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    hburst_type        hburst;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              beat_done;
    logic              burst_done;
    logic              req_timeout;

    int total = 0;
    int bad   = 0;
    int beat_cnt = 0;
    int to_cnt   = 0;
    int snap;

    ahb_master_burst_req #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_write(cmd_write),
        .hreq(hreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
        .hburst(hburst), .hwrite(hwrite), .hsize(hsize),
        .beat_done(beat_done), .burst_done(burst_done), .req_timeout(req_timeout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        if (beat_done === 1'b1) beat_cnt <= beat_cnt + 1;
        if (req_timeout === 1'b1) to_cnt <= to_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge hclk);
    endtask

    logic [31:0] wrap_exp [8];

    initial begin
        wrap_exp = '{32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
        hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = SINGLE;
        cmd_write = 1'b0; hgrant = 1'b0;

        // reset state
        tick(); #1;
        chk("rst_hreq", hreq, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hburst", hburst, SINGLE);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_beat_done", beat_done, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_req_timeout", req_timeout, 0);
        chk("hsize_word", hsize, 3'b010);
        tick(); hreset = 1'b0; #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        // INCR4 write at 0x100, grant held high (also high in IDLE: ignored)
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_burst = INCR4; cmd_write = 1'b1; hgrant = 1'b1; #1;
        chk("t1_idle_ready", cmd_ready, 1);
        chk("t1_idle_hreq", hreq, 0);
        chk("t1_idle_grant_ignored", beat_done, 0);
        tick(); cmd_valid = 1'b0; #1;
        chk("t1_req_hreq", hreq, 1);
        chk("t1_req_htrans", htrans, 2'b00);
        chk("t1_req_ready", cmd_ready, 0);
        chk("t1_req_no_beat", beat_done, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t1_htrans", htrans, (i == 0) ? 2'b10 : 2'b11);
            chk("t1_haddr", haddr, 32'h100 + 32'(4 * i));
            chk("t1_hwrite", hwrite, 1);
            chk("t1_hburst", hburst, INCR4);
            chk("t1_beat_done", beat_done, 1);
            chk("t1_burst_done", burst_done, (i == 3) ? 1 : 0);
        end
        tick(); hgrant = 1'b0; #1;
        chk("t1_end_hreq", hreq, 0);
        chk("t1_end_htrans", htrans, 0);
        chk("t1_end_ready", cmd_ready, 1);

        // WRAP8 read at 0x1C, grant toggling 1,0
        snap = beat_cnt;
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h1C; cmd_burst = WRAP8; cmd_write = 1'b0; #1;
        chk("t2_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b0; #1;
        chk("t2_req_hreq", hreq, 1);
        tick(); hgrant = 1'b1; #1;
        chk("t2_req_still", htrans, 2'b00);
        for (int k = 0; k < 8; k++) begin
            tick(); hgrant = 1'b1; #1;
            chk("t2_haddr", haddr, wrap_exp[k]);
            chk("t2_htrans", htrans, (k == 0) ? 2'b10 : 2'b11);
            chk("t2_beat_done", beat_done, 1);
            chk("t2_burst_done", burst_done, (k == 7) ? 1 : 0);
            if (k < 7) begin
                tick(); hgrant = 1'b0; #1;
                chk("t2_wait_haddr", haddr, wrap_exp[k+1]);
                chk("t2_wait_htrans", htrans, 2'b11);
                chk("t2_wait_beat", beat_done, 0);
                chk("t2_wait_hburst", hburst, WRAP8);
            end
        end
        tick(); hgrant = 1'b0; #1;
        chk("t2_end_hreq", hreq, 0);
        chk("t2_end_ready", cmd_ready, 1);
        chk("t2_beat_count", 64'(beat_cnt - snap), 8);

        // SINGLE at 0x40
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_burst = SINGLE; hgrant = 1'b1; #1;
        tick(); cmd_valid = 1'b0; #1;
        tick(); #1;
        chk("t3_htrans", htrans, 2'b10);
        chk("t3_haddr", haddr, 32'h40);
        chk("t3_beat_done", beat_done, 1);
        chk("t3_burst_done", burst_done, 1);
        tick(); hgrant = 1'b0; #1;
        chk("t3_end_hreq", hreq, 0);
        chk("t3_end_ready", cmd_ready, 1);

        // reset during beat 2 of INCR16 at 0x200; cmd_addr bits [1:0] are dropped
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h203; cmd_burst = INCR16; hgrant = 1'b1; #1;
        tick(); cmd_valid = 1'b0; #1;
        tick(); #1;
        chk("t4_b0_haddr", haddr, 32'h200);
        tick(); #1;
        tick(); #1;
        chk("t4_b2_haddr", haddr, 32'h208);
        hreset = 1'b1; #1;
        chk("t4_rst_hreq", hreq, 0);
        chk("t4_rst_htrans", htrans, 0);
        chk("t4_rst_haddr", haddr, 0);
        chk("t4_rst_hburst", hburst, SINGLE);
        chk("t4_rst_beat", beat_done, 0);
        tick(); hreset = 1'b0; hgrant = 1'b0; #1;
        chk("t4_after_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_burst = INCR4; hgrant = 1'b1; #1;
        tick(); cmd_valid = 1'b0; #1;
        tick(); #1;
        chk("t4_new_htrans", htrans, 2'b10);
        chk("t4_new_haddr", haddr, 32'h300);
        tick(); tick(); tick(); #1;
        chk("t4_new_last", burst_done, 1);
        chk("t4_new_last_addr", haddr, 32'h30C);

        // back-to-back INCR4 with cmd_valid held high
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_burst = INCR4; hgrant = 1'b1; #1;
        snap = beat_cnt;
        chk("t5_idle_ready", cmd_ready, 1);
        tick(); cmd_addr = 32'h500; #1;
        chk("t5_req_ready", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t5_a_haddr", haddr, 32'h400 + 32'(4 * i));
            chk("t5_a_beat", beat_done, 1);
        end
        tick(); #1;
        chk("t5_gap_ready", cmd_ready, 1);
        chk("t5_gap_hreq", hreq, 0);
        tick(); cmd_valid = 1'b0; #1;
        chk("t5_req2_hreq", hreq, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t5_b_haddr", haddr, 32'h500 + 32'(4 * i));
            chk("t5_b_htrans", htrans, (i == 0) ? 2'b10 : 2'b11);
        end
        tick(); #1;
        chk("t5_end_ready", cmd_ready, 1);
        tick(); #1;
        chk("t5_stay_idle", hreq, 0);
        chk("t5_beat_count", 64'(beat_cnt - snap), 8);

        // grant-wait behaviour
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_burst = SINGLE; hgrant = 1'b0; #1;
        snap = to_cnt;
        tick(); cmd_valid = 1'b0; #1;
`ifdef REQ_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            chk("t6_quiet", req_timeout, 0);
            tick(); #1;
        end
        chk("t6_pulse", req_timeout, 1);
        chk("t6_pulse_hreq", hreq, 1);
        tick(); #1;
        chk("t6_after_ready", cmd_ready, 1);
        chk("t6_after_hreq", hreq, 0);
        chk("t6_pulse_count", 64'(to_cnt - snap), 1);
        tick(); cmd_valid = 1'b1; cmd_addr = 32'h84; #1;
        snap = to_cnt;
        tick(); cmd_valid = 1'b0; #1;
        repeat (TO - 1) tick();
        hgrant = 1'b1; #1;
        chk("t6_grant_wins", req_timeout, 0);
        tick(); #1;
        chk("t6_burst_htrans", htrans, 2'b10);
        chk("t6_burst_haddr", haddr, 32'h84);
        tick(); hgrant = 1'b0; #1;
        chk("t6_done_ready", cmd_ready, 1);
        chk("t6_no_pulse", 64'(to_cnt - snap), 0);
`else
        repeat (TO + 4) tick();
        #1;
        chk("t6_wait_hreq", hreq, 1);
        chk("t6_wait_ready", cmd_ready, 0);
        chk("t6_no_timeout", 64'(to_cnt - snap), 0);
        hgrant = 1'b1;
        tick(); #1;
        chk("t6_burst_htrans", htrans, 2'b10);
        chk("t6_burst_haddr", haddr, 32'h80);
        chk("t6_burst_done", burst_done, 1);
        tick(); hgrant = 1'b0; #1;
        chk("t6_done_ready", cmd_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
